// File: rtl/pio_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pio_ctrl_pkg
//   Shared types and constants for the PIO state-machine controller:
//   divider field widths, accumulator widths, the exec FSM state type and a
//   helper that turns the 16.8 divisor fields into the effective divisor.
//
//   Build option: PIO_SM_CTRL_CLKDIV_FRAC_EN selects the fractional divider
//   (see pio_clkdiv); the constants here serve both builds.
// -----------------------------------------------------------------------------
package pio_ctrl_pkg;

  localparam int DIV_INT_W  = 16;
  localparam int DIV_FRAC_W = 8;
  localparam int DIV_W      = DIV_INT_W + DIV_FRAC_W;  // 24
  localparam int ACC_W      = 25;                      // fractional accumulator
  localparam int ACC_INT_W  = 17;                      // integer-only accumulator

  // 1.0 in 16.8 fixed point
  localparam logic [DIV_W-1:0] DIV_ONE = 24'h000100;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } exec_state_e;

  // Effective 16.8 divisor widened to the accumulator width.
  // div_int == 0 encodes 65536.0 (2^24 in 1/256 units). Anything below 1.0
  // is clamped to 1.0 so the divider never produces more than one strobe
  // per cycle.
  function automatic logic [ACC_W-1:0] eff_divisor(
    input logic [DIV_INT_W-1:0]  div_int,
    input logic [DIV_FRAC_W-1:0] div_frac
  );
    logic [ACC_W-1:0] d;
    if (div_int == '0) d = {1'b1, {DIV_W{1'b0}}};
    else               d = {1'b0, div_int, div_frac};
    if (d < ACC_W'(DIV_ONE)) d = ACC_W'(DIV_ONE);
    return d;
  endfunction

endpackage

// File: rtl/pio_clkdiv.sv
// -----------------------------------------------------------------------------
// pio_clkdiv
//   Per-SM clock divider. Every enabled cycle the accumulator advances by one
//   system clock; when it reaches the divisor it wraps (keeping the remainder)
//   and the registered penable strobe fires for one cycle.
//
//   Build option PIO_SM_CTRL_CLKDIV_FRAC_EN:
//     defined   - 16.8 divisor, 25-bit accumulator in 1/256 units
//     undefined - div_frac ignored, 17-bit accumulator in whole cycles
//
// Ports
//   clk, reset   system clock, synchronous active-high reset
//   en           run enable; when low the accumulator holds its phase
//   restart      clear the accumulator (overrides counting)
//   div_int      integer divisor, 0 means 65536
//   div_frac     fractional divisor in 1/256 units
//   penable      registered execute strobe
// -----------------------------------------------------------------------------
module pio_clkdiv
  import pio_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  restart,
  input  logic [DIV_INT_W-1:0]  div_int,
  input  logic [DIV_FRAC_W-1:0] div_frac,
  output logic                  penable
);

`ifdef PIO_SM_CTRL_CLKDIV_FRAC_EN
  localparam int AW = ACC_W;
  localparam logic [AW-1:0] STEP = AW'(DIV_ONE);  // one cycle = 256/256

  logic [AW-1:0] divisor;
  assign divisor = eff_divisor(div_int, div_frac);
`else
  localparam int AW = ACC_INT_W;
  localparam logic [AW-1:0] STEP = AW'(1);

  logic [AW-1:0] divisor;
  logic          unused_frac;
  assign unused_frac = ^div_frac;
  // div_int >= 1 is already >= 1.0, so no clamp is needed here
  assign divisor = (div_int == '0) ? {1'b1, {DIV_INT_W{1'b0}}} : {1'b0, div_int};
`endif

  logic [AW-1:0] acc;
  logic [AW-1:0] acc_step;
  logic          wrap;

  // acc < divisor <= 2^(AW-1), so acc + STEP cannot overflow AW bits
  assign acc_step = acc + STEP;
  assign wrap     = (acc_step >= divisor);

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values and simulation matches the synthesized hardware.
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      acc     <= '0;
      penable <= 1'b0;
    end else if (en) begin
      acc     <= wrap ? (acc_step - divisor) : acc_step;
      penable <= wrap;
    end else begin
      penable <= 1'b0;
    end
  end

endmodule

// File: rtl/pio_sm_ctrl.sv
// -----------------------------------------------------------------------------
// pio_sm_ctrl
//   Per-PIO-block sequencer for NUM_SM state machines: one fractional clock
//   divider per SM producing penable, registered PC-reset pulses, and a
//   two-state exec FSM that injects one host-forced instruction into one SM
//   at a time, waiting while that SM reports a stall.
//
//   Build option: PIO_SM_CTRL_CLKDIV_FRAC_EN enables the fractional part of
//   the 16.8 divider; without it div_frac is ignored.
//
// Parameters
//   NUM_SM    number of state machines (1..4)
//   INSTR_W   forced instruction width
//
// Ports
//   clk, reset       system clock, synchronous active-high reset
//   sm_en            per-SM run enable
//   sm_restart       pulse: restart SM (PC reset + divider phase)
//   clkdiv_restart   pulse: clear divider phase of flagged SMs together
//   div_int          16-bit integer divisor per SM at [16i+:16] (0 = 65536)
//   div_frac         8-bit fractional divisor per SM at [8i+:8]
//   stalled          per-SM stall report for the current instruction
//   exec_valid       host forced-instruction request
//   exec_sm          target SM of the request
//   exec_instr       forced instruction word
//   exec_ready       controller can accept a request this cycle
//   exec_done        pulse: forced instruction retired
//   penable          per-SM execute strobe (registered)
//   pc_reset         per-SM PC reset pulse (registered)
//   imm              one-hot forced-instruction select
//   imm_instr        forced instruction, zero when no imm bit is set
// -----------------------------------------------------------------------------
module pio_sm_ctrl
  import pio_ctrl_pkg::*;
#(
  parameter int NUM_SM  = 4,
  parameter int INSTR_W = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_SM-1:0]              sm_en,
  input  logic [NUM_SM-1:0]              sm_restart,
  input  logic [NUM_SM-1:0]              clkdiv_restart,
  input  logic [DIV_INT_W*NUM_SM-1:0]    div_int,
  input  logic [DIV_FRAC_W*NUM_SM-1:0]   div_frac,
  input  logic [NUM_SM-1:0]              stalled,
  input  logic                           exec_valid,
  input  logic [1:0]                     exec_sm,
  input  logic [INSTR_W-1:0]             exec_instr,
  output logic                           exec_ready,
  output logic                           exec_done,
  output logic [NUM_SM-1:0]              penable,
  output logic [NUM_SM-1:0]              pc_reset,
  output logic [NUM_SM-1:0]              imm,
  output logic [INSTR_W-1:0]             imm_instr
);

  // ---------------------------------------------------------------------------
  // Dividers: a restart of the SM also realigns its divider phase
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_SM; i++) begin : g_div
    pio_clkdiv u_clkdiv (
      .clk      (clk),
      .reset    (reset),
      .en       (sm_en[i]),
      .restart  (sm_restart[i] | clkdiv_restart[i]),
      .div_int  (div_int[DIV_INT_W*i +: DIV_INT_W]),
      .div_frac (div_frac[DIV_FRAC_W*i +: DIV_FRAC_W]),
      .penable  (penable[i])
    );
  end

  // PC reset follows the restart request by one cycle, independent of sm_en
  always_ff @(posedge clk) begin
    if (reset) pc_reset <= '0;
    else       pc_reset <= sm_restart;
  end

  // ---------------------------------------------------------------------------
  // Exec FSM
  // ---------------------------------------------------------------------------
  exec_state_e          state, state_nxt;
  logic [1:0]           lat_sm;
  logic [INSTR_W-1:0]   lat_instr;
  logic                 accept;
  logic [NUM_SM-1:0]    target;
  logic                 target_stalled;
  logic                 target_restart;

  // One-hot of the latched target; an index >= NUM_SM shifts out to zero,
  // which turns the request into a drop: no imm, never stalled, done pulsed.
  assign target         = NUM_SM'(1) << lat_sm;
  assign target_stalled = |(stalled & target);
  assign target_restart = |(sm_restart & target);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      lat_sm    <= '0;
      lat_instr <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        lat_sm    <= exec_sm;
        lat_instr <= exec_instr;
      end
    end
  end

  // Outputs are gated by reset so a reset landing on an ISSUE cycle aborts
  // the instruction without a done pulse, and exec_ready stays low in reset.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_nxt  = state;
    accept     = 1'b0;
    exec_ready = 1'b0;
    exec_done  = 1'b0;
    imm        = '0;
    imm_instr  = '0;
    if (!reset) begin
      case (state)
        IDLE: begin
          exec_ready = 1'b1;
          if (exec_valid) begin
            accept    = 1'b1;
            state_nxt = ISSUE;
          end
        end
        ISSUE: begin
          imm = target;
          if (|target) imm_instr = lat_instr;
          // a restart of the target SM wins over retirement
          if (target_restart) begin
            state_nxt = IDLE;
          end else if (!target_stalled) begin
            exec_done = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pio_sm_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pio_sm_ctrl
//   Directed bench for pio_sm_ctrl (NUM_SM=4). Inputs change 1 time unit after
//   the rising edge; outputs are sampled on the falling edge. Expected values
//   are hand-derived per cycle from the divider and exec-FSM rules.
// -----------------------------------------------------------------------------
module tb_pio_sm_ctrl;

  localparam int NUM_SM  = 4;
  localparam int INSTR_W = 16;

  logic                    clk;
  logic                    reset;
  logic [NUM_SM-1:0]       sm_en;
  logic [NUM_SM-1:0]       sm_restart;
  logic [NUM_SM-1:0]       clkdiv_restart;
  logic [16*NUM_SM-1:0]    div_int;
  logic [8*NUM_SM-1:0]     div_frac;
  logic [NUM_SM-1:0]       stalled;
  logic                    exec_valid;
  logic [1:0]              exec_sm;
  logic [INSTR_W-1:0]      exec_instr;
  logic                    exec_ready;
  logic                    exec_done;
  logic [NUM_SM-1:0]       penable;
  logic [NUM_SM-1:0]       pc_reset;
  logic [NUM_SM-1:0]       imm;
  logic [INSTR_W-1:0]      imm_instr;

  int vectors    = 0;
  int miscompares = 0;

  pio_sm_ctrl #(.NUM_SM(NUM_SM), .INSTR_W(INSTR_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .sm_en          (sm_en),
    .sm_restart     (sm_restart),
    .clkdiv_restart (clkdiv_restart),
    .div_int        (div_int),
    .div_frac       (div_frac),
    .stalled        (stalled),
    .exec_valid     (exec_valid),
    .exec_sm        (exec_sm),
    .exec_instr     (exec_instr),
    .exec_ready     (exec_ready),
    .exec_done      (exec_done),
    .penable        (penable),
    .pc_reset       (pc_reset),
    .imm            (imm),
    .imm_instr      (imm_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Check penable[sm] over n cycles against pat[k] (k = cycle index)
  task automatic run_pen(input string tag, input int sm, input int n, input logic [15:0] pat);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check($sformatf("%s[%0d]", tag, k), 32'(penable[sm]), 32'(pat[k]));
      next_cycle();
    end
  endtask

`ifdef PIO_SM_CTRL_CLKDIV_FRAC_EN
  // D=2.5 after restart: restart cycle 0, then 0,0,1,0,1,0,0,1,0,1
  localparam logic [15:0] PAT_DIV25 = 16'h0528;
`else
  // D=2.5 acts as 2.0: restart cycle 0, then 0,1,0,1,...
  localparam logic [15:0] PAT_DIV25 = 16'h0554;
`endif

  // D=3 after a joint restart: 0 | 0,0,1,0,0,1
  logic [15:0] pat_div3;

  initial begin
    pat_div3       = 16'b0000_0000_0100_1000;
    reset          = 1'b1;
    sm_en          = '0;
    sm_restart     = '0;
    clkdiv_restart = '0;
    div_int        = '0;
    div_frac       = '0;
    stalled        = '0;
    exec_valid     = 1'b0;
    exec_sm        = '0;
    exec_instr     = '0;

    // ---------------- reset state ----------------
    repeat (2) next_cycle();
    @(negedge clk);
    check("rst_exec_ready", 32'(exec_ready), 0);
    check("rst_penable",    32'(penable),    0);
    check("rst_pc_reset",   32'(pc_reset),   0);
    check("rst_imm",        32'(imm),        0);
    check("rst_imm_instr",  32'(imm_instr),  0);
    check("rst_exec_done",  32'(exec_done),  0);
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(exec_ready), 1);
    next_cycle();

    // ---------------- D=1.0: strobe every cycle ----------------
    div_int[15:0] = 16'd1;
    div_frac[7:0] = 8'd0;
    sm_en         = 4'b0001;
    run_pen("div1_pen0", 0, 5, 16'b0000_0000_0001_1110);

    // ---------------- D=2.5 ----------------
    div_int[15:0]  = 16'd2;
    div_frac[7:0]  = 8'd128;
    clkdiv_restart = 4'b0001;
    @(negedge clk);
    check("div1_last_pen0", 32'(penable[0]), 1);
    next_cycle();
    clkdiv_restart = '0;
    run_pen("div2p5_pen0", 0, 11, PAT_DIV25);

    // ---------------- D=3 on SM0/SM1, skewed then realigned ----------------
    div_int[15:0]  = 16'd3;
    div_int[31:16] = 16'd3;
    div_frac       = '0;
    clkdiv_restart = 4'b0001;
    sm_en          = 4'b0001;
    next_cycle();
    clkdiv_restart = '0;
    next_cycle();
    sm_en = 4'b0011;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("skew_a", 32'(penable[1:0]), 32'(2'b01));
    next_cycle();
    clkdiv_restart = 4'b0011;
    @(negedge clk);
    check("skew_b", 32'(penable[1:0]), 32'(2'b10));
    next_cycle();
    clkdiv_restart = '0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      check($sformatf("aligned[%0d]", k), 32'(penable[1:0]), pat_div3[k] ? 32'(2'b11) : 32'(2'b00));
      if (k == 0) check("clkdiv_no_pc_reset", 32'(pc_reset), 0);
      next_cycle();
    end

    // ---------------- disable holds the phase ----------------
    // accumulators sit at 1 (of 3) here; two enabled edges later they wrap
    sm_en = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("en_off_pen[%0d]", k), 32'(penable), 0);
      next_cycle();
    end
    sm_en = 4'b0011;
    next_cycle();
    @(negedge clk);
    check("resume_a", 32'(penable[1:0]), 32'(2'b00));
    next_cycle();
    @(negedge clk);
    check("resume_b", 32'(penable[1:0]), 32'(2'b11));
    next_cycle();
    sm_en = '0;

    // ---------------- exec, target not stalled ----------------
    exec_valid = 1'b1;
    exec_sm    = 2'd1;
    exec_instr = 16'hE001;
    stalled    = 4'b1101;  // other SMs stalled must not matter
    @(negedge clk);
    check("t4_ready_idle", 32'(exec_ready), 1);
    check("t4_imm_idle",   32'(imm),        0);
    next_cycle();
    exec_valid = 1'b0;
    exec_sm    = 2'd0;
    exec_instr = 16'h0000;
    @(negedge clk);
    check("t4_imm",       32'(imm),        32'(4'b0010));
    check("t4_imm_instr", 32'(imm_instr),  32'h0000_E001);
    check("t4_done",      32'(exec_done),  1);
    check("t4_ready",     32'(exec_ready), 0);
    next_cycle();
    @(negedge clk);
    check("t4_imm_after",   32'(imm),        0);
    check("t4_done_after",  32'(exec_done),  0);
    check("t4_ready_after", 32'(exec_ready), 1);
    check("t4_instr_after", 32'(imm_instr),  0);
    next_cycle();

    // ---------------- exec, target stalled 3 cycles ----------------
    exec_valid = 1'b1;
    exec_sm    = 2'd1;
    exec_instr = 16'h1234;
    stalled    = 4'b0010;
    next_cycle();
    // keep a competing request pending; it must not be taken during ISSUE
    exec_sm    = 2'd2;
    exec_instr = 16'hFFFF;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) begin
        stalled    = '0;
        exec_valid = 1'b0;
      end
      @(negedge clk);
      check($sformatf("t5_imm[%0d]", k),   32'(imm),        32'(4'b0010));
      check($sformatf("t5_instr[%0d]", k), 32'(imm_instr),  32'h0000_1234);
      check($sformatf("t5_ready[%0d]", k), 32'(exec_ready), 0);
      check($sformatf("t5_done[%0d]", k),  32'(exec_done),  (k == 3) ? 32'd1 : 32'd0);
      next_cycle();
    end
    @(negedge clk);
    check("t5_imm_after",   32'(imm),        0);
    check("t5_done_after",  32'(exec_done),  0);
    check("t5_ready_after", 32'(exec_ready), 1);
    next_cycle();

    // ---------------- restart aborts a stalled ISSUE ----------------
    exec_valid = 1'b1;
    exec_sm    = 2'd1;
    exec_instr = 16'hABCD;
    next_cycle();
    exec_valid = 1'b0;
    stalled    = 4'b0010;
    sm_restart = 4'b0100;  // a different SM: must not abort
    @(negedge clk);
    check("t6_imm_a",  32'(imm),       32'(4'b0010));
    check("t6_done_a", 32'(exec_done), 0);
    check("t6_pcr_a",  32'(pc_reset),  0);
    next_cycle();
    sm_restart = 4'b0010;
    @(negedge clk);
    check("t6_pcr_b",  32'(pc_reset),  32'(4'b0100));
    check("t6_imm_b",  32'(imm),       32'(4'b0010));
    check("t6_done_b", 32'(exec_done), 0);
    next_cycle();
    sm_restart = '0;
    @(negedge clk);
    check("t6_pcr_c",   32'(pc_reset),   32'(4'b0010));
    check("t6_imm_c",   32'(imm),        0);
    check("t6_done_c",  32'(exec_done),  0);
    check("t6_ready_c", 32'(exec_ready), 1);
    next_cycle();
    stalled = '0;
    @(negedge clk);
    check("t6_pcr_d",  32'(pc_reset),  0);
    check("t6_done_d", 32'(exec_done), 0);
    next_cycle();

    // ---------------- reset during ISSUE ----------------
    exec_valid = 1'b1;
    exec_sm    = 2'd3;
    exec_instr = 16'h5A5A;
    next_cycle();
    exec_valid = 1'b0;
    reset      = 1'b1;
    @(negedge clk);
    check("t7_done_in_rst",  32'(exec_done),  0);
    check("t7_imm_in_rst",   32'(imm),        0);
    check("t7_ready_in_rst", 32'(exec_ready), 0);
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check("t7_ready_after", 32'(exec_ready), 1);
    check("t7_imm_after",   32'(imm),        0);
    check("t7_done_after",  32'(exec_done),  0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
